// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - invaders game-flow controller: lives, waves, hit and wave-clear pauses
module game_fsm #(
  parameter int NUM_INVADERS = 10,
  parameter int NUM_ROWS     = 3,
  parameter int NUM_LIVES    = 3,
  parameter int NUM_WAVES    = 3,
  parameter int PAUSE_CYCLES = 65_000_000,
  localparam int LIVES_W     = $clog2(NUM_LIVES + 1),
  localparam int WAVE_W      = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1,
  localparam int CNT_W       = $clog2(PAUSE_CYCLES + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   player_hit,
  input  logic                                   invaders_landed,
  input  logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]  alive,
  output logic [2:0]                             state,
  output logic [LIVES_W-1:0]                     lives,
  output logic [WAVE_W-1:0]                      wave,
  output logic                                   wave_start,
  output logic                                   player_respawn,
  output logic                                   freeze,
  output logic                                   game_won,
  output logic                                   game_lost
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PLAYING    = 3'd1;
  localparam logic [2:0] ST_HIT_PAUSE  = 3'd2;
  localparam logic [2:0] ST_WAVE_CLEAR = 3'd3;
  localparam logic [2:0] ST_WON        = 3'd4;
  localparam logic [2:0] ST_LOST       = 3'd5;

  localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(NUM_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [WAVE_W-1:0]  WAVE_LAST  = WAVE_W'(NUM_WAVES - 1);
  localparam logic [WAVE_W-1:0]  WAVE_ONE   = WAVE_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0]   cnt;
  logic               armed;
  logic               any_alive;

  logic [2:0]         state_n;
  logic [LIVES_W-1:0] lives_n;
  logic [WAVE_W-1:0]  wave_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               armed_n;
  logic               wave_start_n;
  logic               player_respawn_n;

  assign any_alive = |alive;

  // Next-state, counters and respawn strobes; the first matching PLAYING rule wins.
  always_comb begin
    state_n          = state;
    lives_n          = lives;
    wave_n           = wave;
    cnt_n            = cnt;
    armed_n          = armed;
    wave_start_n     = 1'b0;
    player_respawn_n = 1'b0;

    case (state)
      ST_IDLE, ST_WON, ST_LOST: begin
        if (start) begin
          state_n          = ST_PLAYING;
          lives_n          = LIVES_FULL;
          wave_n           = '0;
          armed_n          = 1'b0;
          wave_start_n     = 1'b1;
          player_respawn_n = 1'b1;
        end
      end

      ST_PLAYING: begin
        if (invaders_landed) begin
          state_n = ST_LOST;
          lives_n = '0;
        end else if (player_hit && (lives <= LIVES_ONE)) begin
          // Last life lost; the <= also keeps lives from ever wrapping.
          state_n = ST_LOST;
          lives_n = '0;
        end else if (player_hit) begin
          state_n = ST_HIT_PAUSE;
          lives_n = lives - LIVES_ONE;
          cnt_n   = CNT_LOAD;
        end else if (armed && !any_alive) begin
          if (wave == WAVE_LAST) begin
            state_n = ST_WON;
          end else begin
            state_n = ST_WAVE_CLEAR;
            cnt_n   = CNT_LOAD;
          end
        end else if (any_alive) begin
          // The formation has been seen on screen, so a later empty mask is a real clear.
          armed_n = 1'b1;
        end
      end

      ST_HIT_PAUSE: begin
        if (cnt == '0) begin
          state_n          = ST_PLAYING;
          player_respawn_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      ST_WAVE_CLEAR: begin
        if (cnt == '0) begin
          state_n          = ST_PLAYING;
          armed_n          = 1'b0;
          wave_start_n     = 1'b1;
          player_respawn_n = 1'b1;
          if (wave != WAVE_LAST) begin
            wave_n = wave + WAVE_ONE;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and decoded outputs, all registered so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      lives          <= LIVES_FULL;
      wave           <= '0;
      cnt            <= '0;
      armed          <= 1'b0;
      wave_start     <= 1'b0;
      player_respawn <= 1'b0;
      freeze         <= 1'b1;
      game_won       <= 1'b0;
      game_lost      <= 1'b0;
    end else begin
      state          <= state_n;
      lives          <= lives_n;
      wave           <= wave_n;
      cnt            <= cnt_n;
      armed          <= armed_n;
      wave_start     <= wave_start_n;
      player_respawn <= player_respawn_n;
      freeze         <= (state_n != ST_PLAYING);
      game_won       <= (state_n == ST_WON);
      game_lost      <= (state_n == ST_LOST);
    end
  end

endmodule
